// File: rtl/vga_dma_copier_pkg.sv
// Shared definitions for the VGA DMA copier: register map offsets,
// default geometry of the frame buffer and the copy engine state encoding.
package vga_dma_copier_pkg;

  localparam logic [7:0] BASE_ADDR_DEFAULT     = 8'hB0;
  localparam int         FB_ADDR_WIDTH_DEFAULT = 15;
  localparam int         FB_SIZE_DEFAULT       = 19200;

  // Register offsets relative to the peripheral base address
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_LEN    = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [7:0] REG_COUNT  = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_PIX,
    ST_DONE
  } dma_state_t;

endpackage

// File: rtl/vga_dma_copier_reg.sv
// Register file of the VGA DMA copier: decodes the five bus addresses,
// holds the programmed source/length/destination and returns register
// contents on the shared bus one cycle after the addressed edge, just like
// the data RAM does.
module dma_reg_file
  import vga_dma_copier_pkg::*;
#(
  parameter logic [7:0] BaseAddr    = BASE_ADDR_DEFAULT,
  parameter int         FbAddrWidth = FB_ADDR_WIDTH_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  inout  wire logic [7:0]        BUS_DATA,
  input  logic [7:0]             BUS_ADDR,
  input  logic                   BUS_WE,
  input  logic                   busy,
  output logic [7:0]             src,
  output logic [7:0]             len,
  output logic [FbAddrWidth-1:0] dst,
  output logic                   start
);

  logic [7:0] offset;
  logic       hit;
  logic [2:0] sel;
  logic [7:0] rd_value;
  logic [7:0] rd_data;
  logic       rd_en;

  assign offset = BUS_ADDR - BaseAddr;
  assign hit    = (offset < REG_COUNT);
  assign sel    = offset[2:0];
  assign start  = BUS_WE && hit && (sel == REG_CTRL) && !busy;

  // Select the register value that a read of the current address returns
  always_comb begin
    rd_value = 8'h00;
    case (sel)
      REG_SRC:    rd_value = src;
      REG_LEN:    rd_value = len;
      REG_DST_LO: rd_value = dst[7:0];
      REG_DST_HI: rd_value = 8'(dst >> 8);
      REG_CTRL:   rd_value = {7'b0, busy};
      default:    rd_value = 8'h00;
    endcase
  end

  // Store processor writes while idle and register the readback value and drive enable
  always_ff @(posedge CLK) begin
    if (RESET) begin
      src     <= 8'h00;
      len     <= 8'h00;
      dst     <= '0;
      rd_data <= 8'h00;
      rd_en   <= 1'b0;
    end else begin
      rd_en   <= hit && !BUS_WE;
      rd_data <= rd_value;
      if (BUS_WE && hit && !busy) begin
        case (sel)
          REG_SRC:    src                <= BUS_DATA;
          REG_LEN:    len                <= BUS_DATA;
          REG_DST_LO: dst[7:0]           <= BUS_DATA;
          REG_DST_HI: dst[FbAddrWidth-1:8] <= BUS_DATA[FbAddrWidth-9:0];
          default:    ;
        endcase
      end
    end
  end

  assign BUS_DATA = rd_en ? rd_data : 8'hzz;

endmodule

// File: rtl/vga_dma_copier.sv
// VGA DMA copier: on START it takes the shared bus, fetches LEN bytes from
// the data RAM starting at SRC, and writes each byte MSB-first as eight
// one-bit pixels into the frame buffer starting at DST, then pulses DMA_IRQ.
module vga_dma_copier
  import vga_dma_copier_pkg::*;
#(
  parameter logic [7:0] BaseAddr    = BASE_ADDR_DEFAULT,
  parameter int         FbAddrWidth = FB_ADDR_WIDTH_DEFAULT,
  parameter int         FbSize      = FB_SIZE_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  inout  wire logic [7:0]        BUS_DATA,
  input  logic [7:0]             BUS_ADDR,
  input  logic                   BUS_WE,
  output logic                   DMA_BUS_REQ,
  input  logic                   DMA_BUS_GNT,
  output logic [7:0]             DMA_ADDR,
  output logic                   DMA_ADDR_EN,
  output logic [FbAddrWidth-1:0] FB_ADDR,
  output logic                   FB_DATA,
  output logic                   FB_WE,
  output logic                   DMA_IRQ
);

  dma_state_t             state;
  logic [7:0]             reg_src;
  logic [7:0]             reg_len;
  logic [FbAddrWidth-1:0] reg_dst;
  logic                   start;
  logic                   busy;
  logic [7:0]             work_src;
  logic [FbAddrWidth-1:0] work_dst;
  logic [7:0]             count;
  logic [7:0]             shift;
  logic [2:0]             pix_cnt;

  localparam logic [FbAddrWidth-1:0] FbLast = FbAddrWidth'(FbSize - 1);

  // Destination steps by one and folds back to pixel 0 at the end of the frame
  function automatic logic [FbAddrWidth-1:0] next_dst(input logic [FbAddrWidth-1:0] d);
    return (d >= FbLast) ? '0 : d + 1'b1;
  endfunction

  assign busy     = (state != ST_IDLE);
  assign DMA_ADDR = work_src;
  assign FB_ADDR  = work_dst;
  assign FB_DATA  = shift[7];

  dma_reg_file #(
    .BaseAddr    (BaseAddr),
    .FbAddrWidth (FbAddrWidth)
  ) u_reg_file (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS_DATA (BUS_DATA),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .busy     (busy),
    .src      (reg_src),
    .len      (reg_len),
    .dst      (reg_dst),
    .start    (start)
  );

  // Copy engine: bus handshake, byte fetch, pixel unpacking and completion pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      DMA_BUS_REQ <= 1'b0;
      DMA_ADDR_EN <= 1'b0;
      FB_WE       <= 1'b0;
      DMA_IRQ     <= 1'b0;
      work_src    <= 8'h00;
      work_dst    <= '0;
      count       <= 8'h00;
      shift       <= 8'h00;
      pix_cnt     <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (reg_len != 8'h00) begin
              state       <= ST_REQ;
              DMA_BUS_REQ <= 1'b1;
              work_src    <= reg_src;
              work_dst    <= reg_dst;
              count       <= reg_len;
            end else begin
              state   <= ST_DONE;
              DMA_IRQ <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (DMA_BUS_GNT) begin
            state       <= ST_ADDR;
            DMA_ADDR_EN <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (!DMA_BUS_GNT) begin
            state       <= ST_REQ;
            DMA_ADDR_EN <= 1'b0;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          DMA_ADDR_EN <= 1'b0;
          if (!DMA_BUS_GNT) begin
            state <= ST_REQ;
          end else begin
            shift   <= BUS_DATA;
            pix_cnt <= 3'd0;
            FB_WE   <= 1'b1;
            state   <= ST_PIX;
          end
        end
        ST_PIX: begin
          shift    <= shift << 1;
          work_dst <= next_dst(work_dst);
          pix_cnt  <= pix_cnt + 3'd1;
          if (pix_cnt == 3'd7) begin
            FB_WE    <= 1'b0;
            work_src <= work_src + 8'd1;
            count    <= count - 8'd1;
            if (count == 8'd1) begin
              state       <= ST_DONE;
              DMA_BUS_REQ <= 1'b0;
              DMA_IRQ     <= 1'b1;
            end else begin
              state       <= ST_ADDR;
              DMA_ADDR_EN <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          DMA_IRQ     <= 1'b0;
          DMA_BUS_REQ <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_dma_copier.sv
// Self-checking bench for vga_dma_copier: models the 128x8 data RAM and the
// top-level bus mux, programs transfers through the register interface and
// compares the frame-buffer pixel stream against a reference built from the
// RAM contents with plain arithmetic.
module tb_vga_dma_copier;

  localparam int         FB_SIZE = 19200;
  localparam logic [7:0] BASE    = 8'hB0;
  localparam logic [7:0] IDLE_A  = 8'hFF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        gnt = 1'b0;
  logic [7:0]  cpuAddr = IDLE_A;
  logic        cpuWe = 1'b0;
  logic        cpuOe = 1'b0;
  logic [7:0]  cpuWdata = 8'h00;
  logic        ramOe = 1'b0;
  logic [7:0]  ramQ = 8'h00;
  logic [7:0]  mem [128];

  wire  [7:0]  busData;
  logic [7:0]  busAddr;
  logic        busWe;
  logic        dmaBusReq;
  logic [7:0]  dmaAddr;
  logic        dmaAddrEn;
  logic [14:0] fbAddr;
  logic        fbData;
  logic        fbWe;
  logic        dmaIrq;

  logic [15:0] fbQ [$];
  int          irqCount = 0;
  int          reqCount = 0;
  int          fbBase;
  int          irqBase;
  int          reqBase;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  assign busAddr = dmaAddrEn ? dmaAddr : cpuAddr;
  assign busWe   = dmaAddrEn ? 1'b0 : cpuWe;
  assign busData = ramOe ? ramQ : (cpuOe ? cpuWdata : 8'hzz);

  vga_dma_copier #(
    .BaseAddr    (BASE),
    .FbAddrWidth (15),
    .FbSize      (FB_SIZE)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BUS_DATA    (busData),
    .BUS_ADDR    (busAddr),
    .BUS_WE      (busWe),
    .DMA_BUS_REQ (dmaBusReq),
    .DMA_BUS_GNT (gnt),
    .DMA_ADDR    (dmaAddr),
    .DMA_ADDR_EN (dmaAddrEn),
    .FB_ADDR     (fbAddr),
    .FB_DATA     (fbData),
    .FB_WE       (fbWe),
    .DMA_IRQ     (dmaIrq)
  );

  // Data RAM with one-cycle registered read on the shared bus
  always @(posedge CLK) begin
    if (!busWe && busAddr < 8'd128) begin
      ramOe <= 1'b1;
      ramQ  <= mem[busAddr[6:0]];
    end else begin
      ramOe <= 1'b0;
    end
  end

  // Record frame-buffer writes, IRQ cycles and request cycles mid-cycle
  always @(negedge CLK) begin
    if (fbWe) fbQ.push_back({fbAddr, fbData});
    if (dmaIrq) irqCount <= irqCount + 1;
    if (dmaBusReq) reqCount <= reqCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    cpuAddr = a; cpuWe = 1'b1; cpuOe = 1'b1; cpuWdata = d;
    @(posedge CLK); #1;
    cpuAddr = IDLE_A; cpuWe = 1'b0; cpuOe = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] a, output logic [7:0] d);
    @(posedge CLK); #1;
    cpuAddr = a; cpuWe = 1'b0;
    @(posedge CLK); #1;
    d = busData;
    cpuAddr = IDLE_A;
  endtask

  task automatic applyStimulus(input int src, input int len, input int dst);
    writeReg(BASE + 8'd0, 8'(src));
    writeReg(BASE + 8'd1, 8'(len));
    writeReg(BASE + 8'd2, 8'(dst));
    writeReg(BASE + 8'd3, 8'(dst >> 8));
    fbBase  = fbQ.size();
    irqBase = irqCount;
    reqBase = reqCount;
    writeReg(BASE + 8'd4, 8'h00);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!dmaIrq && cycles < 400) begin
      @(posedge CLK); #1;
      cycles++;
    end
    checkOutput("irq_seen", 32'(dmaIrq), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("irq_once", 32'(irqCount - irqBase), 32'd1);
    checkOutput("irq_low", 32'(dmaIrq), 32'd0);
  endtask

  // Reference: byte k of the block lands at dst+8k..dst+8k+7, MSB first, wrapping at FB_SIZE
  task automatic checkStream(input string tag, input int src, input int len, input int dst);
    logic [7:0] byteV;
    int idx;
    checkOutput({tag, "_count"}, 32'(fbQ.size() - fbBase), 32'(len * 8));
    for (int k = 0; k < len; k++) begin
      byteV = mem[src + k];
      for (int b = 0; b < 8; b++) begin
        idx = fbBase + k * 8 + b;
        checkOutput($sformatf("%s_pix%0d", tag, k * 8 + b),
                    (idx < fbQ.size()) ? 32'(fbQ[idx]) : 32'hDEAD,
                    32'({15'((dst + k * 8 + b) % FB_SIZE), byteV[7 - b]}));
      end
    end
  endtask

  task automatic runXfer(input string tag, input int src, input int len, input int dst);
    int cyc;
    applyStimulus(src, len, dst);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(1 + 10 * len));
    checkStream(tag, src, len, dst);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] word;
    int          cyc;
    int          src;
    int          len;
    int          dst;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_req", 32'(dmaBusReq), 32'd0);
    checkOutput("rst_addr_en", 32'(dmaAddrEn), 32'd0);
    checkOutput("rst_fb_we", 32'(fbWe), 32'd0);
    checkOutput("rst_irq", 32'(dmaIrq), 32'd0);
    checkOutput("rst_fb_addr", 32'(fbAddr), 32'd0);
    RESET = 1'b0;
    for (int r = 0; r < 5; r++) begin
      readReg(BASE + 8'(r), rd);
      checkOutput($sformatf("rst_reg%0d", r), 32'(rd), 32'd0);
    end

    $display("[TB] directed two-byte copy");
    gnt = 1'b1;
    mem[10] = 8'hA5;
    mem[11] = 8'h0F;
    runXfer("basic", 10, 2, 0);
    word = 16'h0000;
    for (int i = 0; i < 16; i++)
      word = {word[14:0], (fbBase + i < fbQ.size()) ? fbQ[fbBase + i][0] : 1'b0};
    checkOutput("basic_pattern", 32'(word), 32'h0000A50F);

    $display("[TB] zero-length start");
    writeReg(BASE + 8'd1, 8'h00);
    fbBase  = fbQ.size();
    irqBase = irqCount;
    reqBase = reqCount;
    writeReg(BASE + 8'd4, 8'h00);
    waitDone(cyc);
    checkOutput("len0_fast", 32'(cyc <= 1), 32'd1);
    checkOutput("len0_no_req", 32'(reqCount - reqBase), 32'd0);
    checkOutput("len0_no_fb", 32'(fbQ.size() - fbBase), 32'd0);

    $display("[TB] destination wrap");
    mem[20] = 8'hFF;
    runXfer("wrap", 20, 1, FB_SIZE - 2);

    $display("[TB] grant drop during second byte fetch");
    mem[30] = 8'h3C;
    mem[31] = 8'h96;
    applyStimulus(30, 2, 100);
    cyc = 0;
    while (!fbWe && cyc < 50) begin @(posedge CLK); #1; cyc++; end
    while (fbWe && cyc < 50) begin @(posedge CLK); #1; cyc++; end
    checkOutput("drop_in_addr", 32'(dmaAddrEn), 32'd1);
    @(posedge CLK); #1;
    gnt = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("drop_req_held", 32'(dmaBusReq), 32'd1);
    checkOutput("drop_no_fb", 32'(fbWe), 32'd0);
    gnt = 1'b1;
    waitDone(cyc);
    checkStream("drop", 30, 2, 100);

    $display("[TB] register writes while busy");
    gnt = 1'b0;
    applyStimulus(40, 1, 500);
    writeReg(BASE + 8'd1, 8'h33);
    writeReg(BASE + 8'd0, 8'h55);
    readReg(BASE + 8'd1, rd);
    checkOutput("busy_len", 32'(rd), 32'd1);
    readReg(BASE + 8'd0, rd);
    checkOutput("busy_src", 32'(rd), 32'd40);
    readReg(BASE + 8'd4, rd);
    checkOutput("busy_ctrl", 32'(rd), 32'h01);
    gnt = 1'b1;
    waitDone(cyc);
    checkStream("busy", 40, 1, 500);
    readReg(BASE + 8'd4, rd);
    checkOutput("idle_ctrl", 32'(rd), 32'h00);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 6; t++) begin
      len = int'($urandom_range(1, 4));
      src = int'($urandom_range(0, 127 - len));
      dst = (t == 2) ? FB_SIZE - int'($urandom_range(1, 20)) : int'($urandom_range(0, FB_SIZE - 1));
      runXfer($sformatf("rnd%0d", t), src, len, dst);
    end

    $display("[TB] reset in the middle of pixel writes");
    mem[50] = 8'hFF;
    applyStimulus(50, 3, 0);
    cyc = 0;
    while (!fbWe && cyc < 50) begin @(posedge CLK); #1; cyc++; end
    checkOutput("mid_fb_active", 32'(fbWe), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    checkOutput("mid_rst_fb_we", 32'(fbWe), 32'd0);
    checkOutput("mid_rst_req", 32'(dmaBusReq), 32'd0);
    checkOutput("mid_rst_irq", 32'(dmaIrq), 32'd0);
    checkOutput("mid_rst_addr_en", 32'(dmaAddrEn), 32'd0);
    RESET = 1'b0;
    for (int r = 0; r < 5; r++) begin
      readReg(BASE + 8'(r), rd);
      checkOutput($sformatf("mid_rst_reg%0d", r), 32'(rd), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
